// File: rtl/bcd_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bcd_pkg
// Description : Shared BCD constants, the digit type and a validity helper
//               used by the cascaded BCD counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_MAX = 9;
    localparam int BCD_W   = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // True for the six codes 10..15 that are not legal decimal digits
    function automatic logic bcd_invalid(input bcd_digit_t v);
        return (v > bcd_digit_t'(BCD_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter_if.sv
`default_nettype none
// ============================================================================
// Interface   : bcd_counter_if
// Description : Control / data bundle between a BCD counter and its driver.
//               The dn (direction) signal exists only when
//               BCD_COUNTER_DOWN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_counter_if #(
    parameter int DIGITS = 4
) ();
    import bcd_pkg::*;

    logic                      en;
    logic                      ld;
    logic [BCD_W*DIGITS-1:0]   d;
    logic [BCD_W*DIGITS-1:0]   q;
    logic                      co;
    logic                      err;
`ifdef BCD_COUNTER_DOWN_EN
    logic                      dn;
`endif

`ifdef BCD_COUNTER_DOWN_EN
    modport master (output en, ld, d, dn, input q, co, err);
    modport slave  (input en, ld, d, dn, output q, co, err);
`else
    modport master (output en, ld, d, input q, co, err);
    modport slave  (input en, ld, d, output q, co, err);
`endif

endinterface
`default_nettype wire

// File: rtl/bcd_counter_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit
// Description : One decade of the BCD counter. Advances when the global step
//               and its carry-in are both set; reports carry-out when it is
//               also at its terminal value (9 counting up, 0 counting down).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_step,
    input  wire logic       i_cin,
    input  wire logic       i_dir,
    input  wire logic       i_load,
    input  wire bcd_digit_t i_ld_val,
    output bcd_digit_t      o_digit,
    output logic            o_cout
);

    localparam bcd_digit_t C_MAX  = bcd_digit_t'(BCD_MAX);
    localparam bcd_digit_t C_ZERO = '0;

    bcd_digit_t r_digit;
    bcd_digit_t w_next;
    logic       w_adv;
    logic       w_terminal;

    assign w_adv      = i_step & i_cin;
    assign w_terminal = i_dir ? (r_digit == C_ZERO) : (r_digit == C_MAX);
    assign o_cout     = w_adv & w_terminal;
    assign o_digit    = r_digit;

    // Next value of this decade when it advances, wrapping 9<->0
    always_comb begin
        w_next = r_digit;
        if (i_dir) begin
            w_next = w_terminal ? C_MAX : (r_digit - bcd_digit_t'(1));
        end else begin
            w_next = w_terminal ? C_ZERO : (r_digit + bcd_digit_t'(1));
        end
    end

    // Digit register: reset, then load (illegal codes load as 0), then advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= C_ZERO;
        end else if (i_load) begin
            r_digit <= bcd_invalid(i_ld_val) ? C_ZERO : i_ld_val;
        end else if (w_adv) begin
            r_digit <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : Cascaded DIGITS-decade BCD counter with a DIV prescaler,
//               synchronous load with illegal-digit flag and a combinational
//               carry/borrow out. Define BCD_COUNTER_DOWN_EN to add the dn
//               input and bidirectional counting.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bcd_counter_if.slave bus
);

    localparam int             PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             r_err;
    logic             w_pre_last;
    logic             w_step;
    logic             w_dir;
    logic [DIGITS:0]  w_carry;
    logic [DIGITS-1:0] w_bad;

    // A load or reset in the same cycle suppresses the step so CO stays low
    assign w_pre_last = (r_pre == C_PRE_LAST);
    assign w_step     = bus.en & w_pre_last & ~bus.ld & ~rst;
    assign w_carry[0] = 1'b1;

`ifdef BCD_COUNTER_DOWN_EN
    assign w_dir = bus.dn;
`else
    assign w_dir = 1'b0;
`endif

    // Prescaler: counts enabled cycles 0..DIV-1, cleared by reset and load
    always_ff @(posedge clk) begin
        if (rst || bus.ld) begin
            r_pre <= '0;
        end else if (bus.en) begin
            r_pre <= w_pre_last ? '0 : (r_pre + PRE_W'(1));
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_t w_q;

            assign w_bad[gi] = bcd_invalid(bus.d[gi*BCD_W +: BCD_W]);
            assign bus.q[gi*BCD_W +: BCD_W] = w_q;

            bcd_digit u_digit (
                .clk      (clk),
                .rst      (rst),
                .i_step   (w_step),
                .i_cin    (w_carry[gi]),
                .i_dir    (w_dir),
                .i_load   (bus.ld),
                .i_ld_val (bus.d[gi*BCD_W +: BCD_W]),
                .o_digit  (w_q),
                .o_cout   (w_carry[gi+1])
            );
        end
    endgenerate

    // Error flag reflects only the load taken on the most recent edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= bus.ld & (|w_bad);
        end
    end

    assign bus.co  = w_carry[DIGITS];
    assign bus.err = r_err;

endmodule
`default_nettype wire
